// File: rtl/cal_core_feeder.sv
// Sequencer for the calculation core: streams H rows and alpha columns per row,
// waits for each beta, re-emits it tagged with its row, and pulses done after the last row.
module cal_core_feeder #(
  parameter int J       = 14,
  parameter int I       = 7,
  parameter int A       = 2,
  parameter int TIMEOUT = 4096,
  localparam int I_WIDTH = $clog2(I) + 1,
  localparam int A_WIDTH = $clog2(A) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 h_wr_en,
  input  logic [I_WIDTH-1:0]   h_wr_row,
  input  logic [J-1:0]         h_wr_data,
  input  logic                 a_wr_en,
  input  logic [I_WIDTH-1:0]   a_wr_row,
  input  logic [A_WIDTH-1:0]   a_wr_col,
  input  logic [J*64-1:0]      a_wr_data,
  input  logic                 start,
  output logic [J-1:0]         H_row,
  output logic                 H_row_tvalid,
  output logic [J*64-1:0]      alpha_u_col,
  output logic                 alpha_u_col_tvalid,
  output logic                 alpha_u_col_tlast,
  input  logic [A*64-1:0]      beta,
  input  logic                 beta_tvalid,
  output logic [A*64-1:0]      beta_out,
  output logic [I_WIDTH-1:0]   beta_out_row,
  output logic                 beta_out_tvalid,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic                 err_stray
);

  localparam int CW = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {IDLE, SEND_H, SEND_A, WAIT_B} state_t;

  state_t               state, state_d;
  logic [I_WIDTH-1:0]   row, row_d, rd_row;
  logic [A_WIDTH-1:0]   col, col_d, rd_col;
  logic [CW-1:0]        wait_cnt, wait_cnt_d;
  logic [J-1:0]         h_mem [I];
  logic [J*64-1:0]      a_mem [I][A];
  logic [J-1:0]         h_rd;
  logic [J*64-1:0]      a_rd;
  logic                 start_acc, wr_ok;

  logic [J-1:0]         h_row_d;
  logic [J*64-1:0]      a_col_d;
  logic [A*64-1:0]      bo_d;
  logic [I_WIDTH-1:0]   bo_row_d;
  logic                 h_vld_d, a_vld_d, a_last_d, bo_vld_d, done_d, err_to_d, err_st_d;

  // A start landing on the done cycle is dropped; writes freeze once a run is accepted.
  assign start_acc = start && (state == IDLE) && !done;
  assign wr_ok     = !busy && !start_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < I; r++) begin
        h_mem[r] <= '0;
        for (int a = 0; a < A; a++) a_mem[r][a] <= '0;
      end
    end else if (wr_ok) begin
      for (int r = 0; r < I; r++) begin
        if (h_wr_en && h_wr_row == I_WIDTH'(r)) h_mem[r] <= h_wr_data;
        for (int a = 0; a < A; a++)
          if (a_wr_en && a_wr_row == I_WIDTH'(r) && a_wr_col == A_WIDTH'(a))
            a_mem[r][a] <= a_wr_data;
      end
    end
  end

  // Read address is the row/column about to be presented on the next cycle.
  always_comb begin
    rd_row = row;
    rd_col = col + A_WIDTH'(1);
    case (state)
      IDLE:    rd_row = '0;
      SEND_H:  rd_col = '0;
      WAIT_B:  rd_row = row + I_WIDTH'(1);
      default: ;
    endcase
  end

  always_comb begin
    h_rd = '0;
    a_rd = '0;
    for (int r = 0; r < I; r++) begin
      if (rd_row == I_WIDTH'(r)) begin
        h_rd = h_mem[r];
        for (int a = 0; a < A; a++)
          if (rd_col == A_WIDTH'(a)) a_rd = a_mem[r][a];
      end
    end
  end

  always_comb begin
    state_d    = state;
    row_d      = row;
    col_d      = col;
    wait_cnt_d = wait_cnt;
    h_row_d    = H_row;
    a_col_d    = alpha_u_col;
    bo_d       = beta_out;
    bo_row_d   = beta_out_row;
    h_vld_d    = 1'b0;
    a_vld_d    = 1'b0;
    a_last_d   = 1'b0;
    bo_vld_d   = 1'b0;
    done_d     = 1'b0;
    err_to_d   = err_timeout;
    err_st_d   = err_stray;
    case (state)
      IDLE: if (start_acc) begin
        state_d  = SEND_H;
        row_d    = '0;
        h_row_d  = h_rd;
        h_vld_d  = 1'b1;
        err_to_d = 1'b0;
        err_st_d = 1'b0;
      end
      SEND_H: begin
        state_d  = SEND_A;
        col_d    = '0;
        a_col_d  = a_rd;
        a_vld_d  = 1'b1;
        a_last_d = (rd_col == A_WIDTH'(A - 1));
      end
      SEND_A: begin
        if (col == A_WIDTH'(A - 1)) begin
          state_d    = WAIT_B;
          wait_cnt_d = '0;
        end else begin
          col_d    = rd_col;
          a_col_d  = a_rd;
          a_vld_d  = 1'b1;
          a_last_d = (rd_col == A_WIDTH'(A - 1));
        end
      end
      WAIT_B: begin
        if (beta_tvalid) begin
          bo_d     = beta;
          bo_row_d = row;
          bo_vld_d = 1'b1;
          if (row == I_WIDTH'(I - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SEND_H;
            row_d   = rd_row;
            h_row_d = h_rd;
            h_vld_d = 1'b1;
          end
        end else if (TIMEOUT != 0 && wait_cnt == CW'(TIMEOUT - 1)) begin
          state_d  = IDLE;
          err_to_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Evaluated after the start clear so a stray beat on the start cycle still flags.
    if (beta_tvalid && state != WAIT_B) err_st_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      row                <= '0;
      col                <= '0;
      wait_cnt           <= '0;
      H_row              <= '0;
      H_row_tvalid       <= 1'b0;
      alpha_u_col        <= '0;
      alpha_u_col_tvalid <= 1'b0;
      alpha_u_col_tlast  <= 1'b0;
      beta_out           <= '0;
      beta_out_row       <= '0;
      beta_out_tvalid    <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      err_timeout        <= 1'b0;
      err_stray          <= 1'b0;
    end else begin
      state              <= state_d;
      row                <= row_d;
      col                <= col_d;
      wait_cnt           <= wait_cnt_d;
      H_row              <= h_row_d;
      H_row_tvalid       <= h_vld_d;
      alpha_u_col        <= a_col_d;
      alpha_u_col_tvalid <= a_vld_d;
      alpha_u_col_tlast  <= a_last_d;
      beta_out           <= bo_d;
      beta_out_row       <= bo_row_d;
      beta_out_tvalid    <= bo_vld_d;
      busy               <= (state_d != IDLE);
      done               <= done_d;
      err_timeout        <= err_to_d;
      err_stray          <= err_st_d;
    end
  end

endmodule

// File: tb/tb_cal_core_feeder.sv
// Bench for cal_core_feeder: core model echoes lane 0 of each column as beta two cycles
// after tlast; a scoreboard checks every beta_out, per-test tasks check stream timing/content.
module tb_cal_core_feeder;
  localparam int J = 14, I = 7, A = 2, TO = 16;
  localparam int IW = $clog2(I) + 1, AW = $clog2(A) + 1;

  logic clk = 0, rst_n = 1;
  logic h_wr_en = 0, a_wr_en = 0, start = 0;
  logic [IW-1:0] h_wr_row = '0, a_wr_row = '0;
  logic [AW-1:0] a_wr_col = '0;
  logic [J-1:0] h_wr_data = '0;
  logic [J*64-1:0] a_wr_data = '0;
  logic [J-1:0] H_row;
  logic H_row_tvalid, alpha_u_col_tvalid, alpha_u_col_tlast;
  logic [J*64-1:0] alpha_u_col;
  logic [A*64-1:0] beta, beta_out;
  logic beta_tvalid, beta_out_tvalid, busy, done, err_timeout, err_stray;
  logic [IW-1:0] beta_out_row;

  logic model_bv = 0, stray_bv = 0;
  logic [A*64-1:0] model_beta = '0, stray_beta = '0;
  assign beta_tvalid = model_bv | stray_bv;
  assign beta        = stray_bv ? stray_beta : model_beta;

  cal_core_feeder #(.J(J), .I(I), .A(A), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_wr_en(h_wr_en), .h_wr_row(h_wr_row), .h_wr_data(h_wr_data),
    .a_wr_en(a_wr_en), .a_wr_row(a_wr_row), .a_wr_col(a_wr_col), .a_wr_data(a_wr_data),
    .start(start),
    .H_row(H_row), .H_row_tvalid(H_row_tvalid),
    .alpha_u_col(alpha_u_col), .alpha_u_col_tvalid(alpha_u_col_tvalid),
    .alpha_u_col_tlast(alpha_u_col_tlast),
    .beta(beta), .beta_tvalid(beta_tvalid),
    .beta_out(beta_out), .beta_out_row(beta_out_row), .beta_out_tvalid(beta_out_tvalid),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [J-1:0] d; } h_rec_t;
  typedef struct { int cyc; logic [J*64-1:0] d; logic last; } a_rec_t;
  typedef struct { int row; logic [A*64-1:0] b; } exp_t;
  h_rec_t h_q[$];
  a_rec_t a_q[$];
  int     done_q[$];
  exp_t   exp_q[$];

  int n_chk = 0, n_fail = 0;
  bit hold_en = 0, exp_zero = 0;
  int hold_row = 0;

  function automatic logic [63:0] pat(int r, int a, int j);
    return {8'hA5, 8'(r), 16'(a), 16'(j), 16'h5A5A};
  endfunction

  function automatic logic [J*64-1:0] col_pat(int r, int a);
    logic [J*64-1:0] v;
    for (int j = 0; j < J; j++) v[j*64 +: 64] = pat(r, a, j);
    return v;
  endfunction

  // Core model: row number comes from counting H beats in this run, not from the DUT.
  initial begin : core_model
    int pend, hcnt, mrow, k;
    logic [63:0] cap [A];
    exp_t e;
    pend = 0; hcnt = 0; mrow = 0; k = 0;
    forever begin
      @(negedge clk);
      model_bv = 0;
      if (!rst_n || !busy) begin
        pend = 0; hcnt = 0; k = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            for (int a = 0; a < A; a++) begin
              model_beta[a*64 +: 64] = cap[a];
              e.b[a*64 +: 64] = exp_zero ? 64'd0 : pat(mrow, a, 0);
            end
            e.row = mrow;
            model_bv = 1;
            exp_q.push_back(e);
          end
        end
        if (H_row_tvalid) begin mrow = hcnt; hcnt++; k = 0; end
        if (alpha_u_col_tvalid) begin
          if (k < A) cap[k] = alpha_u_col[63:0];
          k++;
          if (alpha_u_col_tlast && !(hold_en && mrow == hold_row)) pend = 2;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (H_row_tvalid) h_q.push_back('{cyc, H_row});
      if (alpha_u_col_tvalid) a_q.push_back('{cyc, alpha_u_col, alpha_u_col_tlast});
      if (done) done_q.push_back(cyc);
      if (H_row_tvalid || alpha_u_col_tvalid) begin
        n_chk++;
        if (H_row_tvalid && alpha_u_col_tvalid) begin
          n_fail++;
          $display("FAIL tvalid_overlap: both tvalids 1 at cycle %0d, required exclusive", cyc);
        end
      end
      if (beta_out_tvalid) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beta_out_unexpected: row %0d at cycle %0d, required no output", beta_out_row, cyc);
        end else begin
          e = exp_q.pop_front();
          if (beta_out_row !== IW'(e.row) || beta_out !== e.b) begin
            n_fail++;
            $display("FAIL beta_out: row %0d data %h, required row %0d data %h", beta_out_row, beta_out, e.row, e.b);
          end
        end
      end
    end
  end

  task automatic clear_q();
    h_q.delete(); a_q.delete(); done_q.delete(); exp_q.delete();
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk); start = 1; s = cyc;
    @(negedge clk); start = 0;
  endtask

  task automatic load_mem();
    for (int r = 0; r < I; r++)
      for (int a = 0; a < A; a++) begin
        @(negedge clk);
        h_wr_en = 1; h_wr_row = IW'(r); h_wr_data = J'(1) << r;
        a_wr_en = 1; a_wr_row = IW'(r); a_wr_col = AW'(a); a_wr_data = col_pat(r, a);
      end
    @(negedge clk); h_wr_en = 0; a_wr_en = 0;
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({H_row_tvalid, alpha_u_col_tvalid, alpha_u_col_tlast, beta_out_tvalid, busy, done, err_timeout, err_stray} !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: %b, required 00000000", {H_row_tvalid, alpha_u_col_tvalid, alpha_u_col_tlast, beta_out_tvalid, busy, done, err_timeout, err_stray});
    end
    n_chk++;
    if ((|H_row) || (|alpha_u_col) || (|beta_out) || (|beta_out_row)) begin
      n_fail++;
      $display("FAIL reset_data: H_row %h beta_out_row %0d, required all data zero", H_row, beta_out_row);
    end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_full_run();
    int s, d;
    clear_q(); hold_en = 0; exp_zero = 0;
    pulse_start(s);
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: %b, required 1", busy); end
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    d = cyc;
    n_chk++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL full_done_timeout: done %b, required 1", done); end
    n_chk++;
    if (d - s - 1 !== 35 || busy !== 1'b0) begin
      n_fail++; $display("FAIL run_length: %0d edges busy %b, required 35 edges busy 0", d - s - 1, busy);
    end
    @(negedge clk);
    n_chk++;
    if (h_q.size() != I || a_q.size() != I*A || done_q.size() != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_counts: h %0d a %0d done %0d pend %0d, required %0d %0d 1 0", h_q.size(), a_q.size(), done_q.size(), exp_q.size(), I, I*A);
    end
    for (int r = 0; r < I && r < h_q.size(); r++) begin
      n_chk++;
      if (h_q[r].d !== J'(1) << r || h_q[r].cyc != s + 1 + 5*r) begin
        n_fail++; $display("FAIL h_row%0d: %h at %0d, required %h at %0d", r, h_q[r].d, h_q[r].cyc, J'(1) << r, s + 1 + 5*r);
      end
    end
    for (int k = 0; k < I*A && k < a_q.size(); k++) begin
      n_chk++;
      if (a_q[k].d !== col_pat(k/A, k%A) || a_q[k].last !== (k%A == A-1) || a_q[k].cyc != s + 2 + 5*(k/A) + k%A) begin
        n_fail++;
        $display("FAIL alpha_beat%0d: lane0 %h last %b at %0d, required %h last %b at %0d", k, a_q[k].d[63:0], a_q[k].last, a_q[k].cyc, pat(k/A, k%A, 0), (k%A == A-1), s + 2 + 5*(k/A) + k%A);
      end
    end
  endtask

  task automatic test_timeout();
    int s, e, tl, nt;
    clear_q(); hold_en = 1; hold_row = 3;
    pulse_start(s);
    for (int i = 0; i < 200 && !err_timeout; i++) @(negedge clk);
    e = cyc;
    n_chk++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL timeout_flag: err %b busy %b done %b, required 1 0 0", err_timeout, busy, done);
    end
    tl = -1; nt = 0;
    foreach (a_q[k]) if (a_q[k].last) begin if (nt == 3) tl = a_q[k].cyc; nt++; end
    n_chk++;
    if (tl != s + 18 || e - tl != TO + 1) begin
      n_fail++; $display("FAIL timeout_timing: tlast %0d err %0d, required tlast %0d err %0d", tl, e, s + 18, s + 18 + TO + 1);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (done_q.size() != 0 || err_timeout !== 1'b1 || h_q.size() != 4 || busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_after: done %0d err %b h %0d busy %b, required 0 1 4 0", done_q.size(), err_timeout, h_q.size(), busy);
    end
    hold_en = 0; clear_q();
    pulse_start(s);
    n_chk++;
    if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: %b, required 0", err_timeout); end
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    n_chk++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL timeout_rerun_done: %b, required 1", done); end
    @(negedge clk);
  endtask

  task automatic test_stray();
    int s, nb;
    @(negedge clk); stray_beta = {2{64'hFEED_0000_BEEF_0001}}; stray_bv = 1;
    @(negedge clk); stray_bv = 0;
    n_chk++;
    if (err_stray !== 1'b1 || beta_out_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL stray_idle: err %b bo_vld %b, required 1 0", err_stray, beta_out_tvalid);
    end
    clear_q();
    pulse_start(s);
    n_chk++;
    if (err_stray !== 1'b0) begin n_fail++; $display("FAIL stray_clear: %b, required 0", err_stray); end
    nb = 0;
    for (int i = 0; i < 50 && nb < 5; i++) begin
      @(negedge clk);
      if (alpha_u_col_tvalid) nb++;
    end
    stray_bv = 1;
    @(negedge clk); stray_bv = 0;
    n_chk++;
    if (err_stray !== 1'b1 || beta_out_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL stray_send_a: err %b bo_vld %b, required 1 0", err_stray, beta_out_tvalid);
    end
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (done_q.size() != 1 || h_q.size() != I || a_q.size() != I*A || exp_q.size() != 0 || err_stray !== 1'b1) begin
      n_fail++; $display("FAIL stray_run: done %0d h %0d a %0d pend %0d err %b, required 1 %0d %0d 0 1", done_q.size(), h_q.size(), a_q.size(), exp_q.size(), err_stray, I, I*A);
    end
  endtask

  task automatic test_ignored();
    int s;
    bit got;
    @(negedge clk);
    h_wr_en = 1; h_wr_row = IW'(8); h_wr_data = 14'h2AAA;
    a_wr_en = 1; a_wr_row = '0; a_wr_col = AW'(2); a_wr_data = '1;
    @(negedge clk); h_wr_en = 0; a_wr_en = 0;
    clear_q();
    pulse_start(s);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = 0; h_wr_en = 0;
      if (done) begin start = 1; got = 1; break; end
      if (i == 5) begin start = 1; h_wr_en = 1; h_wr_row = IW'(6); h_wr_data = 14'h1555; end
    end
    @(negedge clk); start = 0;
    n_chk++;
    if (!got || busy !== 1'b0 || H_row_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL start_in_done: done_seen %b busy %b hvld %b, required 1 0 0", got, busy, H_row_tvalid);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (h_q.size() != I || done_q.size() != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL no_restart: h %0d done %0d busy %b, required %0d 1 0", h_q.size(), done_q.size(), busy, I);
    end
    n_chk++;
    if (h_q.size() != I || h_q[0].d !== 14'h0001 || h_q[6].d !== 14'h0040) begin
      n_fail++; $display("FAIL dropped_h_writes: row0 %h row6 %h, required 0001 0040", h_q.size() > 0 ? h_q[0].d : 14'h0, h_q.size() == I ? h_q[6].d : 14'h0);
    end
    n_chk++;
    if (a_q.size() == 0 || a_q[0].d !== col_pat(0, 0)) begin
      n_fail++; $display("FAIL dropped_a_write: row0 col0 lane0 %h, required %h", a_q.size() > 0 ? a_q[0].d[63:0] : 64'h0, pat(0, 0, 0));
    end
  endtask

  task automatic test_reset_mid();
    int s, nb;
    clear_q();
    pulse_start(s);
    nb = 0;
    for (int i = 0; i < 100 && nb < 9; i++) begin
      @(negedge clk);
      if (alpha_u_col_tvalid) nb++;
    end
    rst_n = 0;
    #1;
    n_chk++;
    if ({H_row_tvalid, alpha_u_col_tvalid, alpha_u_col_tlast, beta_out_tvalid, busy, done} !== 6'h0 || (|alpha_u_col) || (|H_row) || (|beta_out)) begin
      n_fail++; $display("FAIL reset_mid: ctrl %b, required 000000 and zero data", {H_row_tvalid, alpha_u_col_tvalid, alpha_u_col_tlast, beta_out_tvalid, busy, done});
    end
    @(negedge clk); rst_n = 1;
    clear_q(); exp_zero = 1;
    pulse_start(s);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (h_q.size() != I || done_q.size() != 1 || exp_q.size() != 0 || (h_q.size() > 0 && h_q[0].cyc != s + 1)) begin
      n_fail++; $display("FAIL reset_rerun: h %0d done %0d pend %0d, required %0d 1 0 from row 0", h_q.size(), done_q.size(), exp_q.size(), I);
    end
    n_chk++;
    if (h_q.size() == 0 || h_q[0].d !== '0 || a_q.size() == 0 || a_q[0].d !== '0) begin
      n_fail++; $display("FAIL reset_mem_cleared: H row0 %h alpha lane0 %h, required 0 0", h_q.size() > 0 ? h_q[0].d : 14'h0, a_q.size() > 0 ? a_q[0].d[63:0] : 64'h0);
    end
  endtask

  initial begin
    test_reset();
    load_mem();
    test_full_run();
    test_timeout();
    test_stray();
    test_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
